// File: rtl/inst_fetch.sv
// Instruction-fetch unit: owns the PC and assembles each 32-bit instruction from
// four byte reads over the shared 8-bit memory port, stalling the pipeline until complete.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        stallreq_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTES  = 4;

  logic [ADDR_W-1:0] pc,       pc_n;
  logic [CNT_W-1:0]  iss_cnt,  iss_cnt_n;
  logic [CNT_W-1:0]  cap_cnt,  cap_cnt_n;
  logic              rd_valid, rd_valid_n;
  logic [IDX_W-1:0]  rd_idx,   rd_idx_n;
  logic [INST_W-1:0] inst_buf, inst_buf_n;

  logic done;
  logic issue;

  // Only stall[0] matters to IF; the upper bits are folded into a sink.
  logic unused_stall_hi;
  assign unused_stall_hi = ^stall[5:1];

  assign done       = (cap_cnt == CNT_W'(BYTES));
  assign mem_req_o  = (iss_cnt < CNT_W'(BYTES));
  assign mem_addr_o = pc + ADDR_W'(iss_cnt);
  assign issue      = mem_req_o && mem_grant_i;
  assign if_pc_o    = pc;
  assign if_inst_o  = done ? inst_buf : '0;
  assign stallreq_o = !done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      iss_cnt  <= '0;
      cap_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      inst_buf <= '0;
    end else begin
      pc       <= pc_n;
      iss_cnt  <= iss_cnt_n;
      cap_cnt  <= cap_cnt_n;
      rd_valid <= rd_valid_n;
      rd_idx   <= rd_idx_n;
      inst_buf <= inst_buf_n;
    end
  end

  // Next state: redirect > advance/hold > issue/capture
  always_comb begin
    pc_n       = pc;
    iss_cnt_n  = iss_cnt;
    cap_cnt_n  = cap_cnt;
    rd_valid_n = rd_valid;
    rd_idx_n   = rd_idx;
    inst_buf_n = inst_buf;

    if (branch_flag_i) begin
      pc_n       = branch_target_i;
      iss_cnt_n  = '0;
      cap_cnt_n  = '0;
      rd_valid_n = 1'b0;
      inst_buf_n = '0;
    end else if (done) begin
      if (!stall[0]) begin
        pc_n       = pc + ADDR_W'(BYTES);
        iss_cnt_n  = '0;
        cap_cnt_n  = '0;
        rd_valid_n = 1'b0;
        inst_buf_n = '0;
      end
    end else begin
      // stall[0] is ignored while incomplete, else IF would wait on its own stallreq
      if (issue) begin
        iss_cnt_n  = iss_cnt + CNT_W'(1);
        rd_valid_n = 1'b1;
        rd_idx_n   = iss_cnt[IDX_W-1:0];
      end else begin
        rd_valid_n = 1'b0;
      end
      if (rd_valid) begin
        inst_buf_n[{rd_idx, 3'b000} +: 8] = mem_data_i;
        cap_cnt_n = cap_cnt + CNT_W'(1);
      end
    end
  end

endmodule
